// File: rtl/led_blink_checker.sv
// Measures the half-period of an asynchronous LED signal, counts its edges and
// tracks whether it blinks steadily within tolerance of the expected rate.
module led_blink_checker #(
    parameter int NUM_COUNT = 5,
    parameter int TOL       = 1,
    parameter int CNT_W     = 24,
    parameter int LOCK_N    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             led_in,
    input  logic             clr,
    output logic [CNT_W-1:0] half_period,
    output logic             period_vld,
    output logic [15:0]      toggles,
    output logic             locked,
    output logic             err,
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

    localparam int                      MW     = $clog2(LOCK_N + 1);
    localparam logic [MW-1:0]           LOCK_M = MW'(LOCK_N);
    localparam logic [CNT_W-1:0]        TO_LIM = CNT_W'(2 * (NUM_COUNT + TOL));
    localparam logic signed [CNT_W:0]   NUM_S  = (CNT_W+1)'(NUM_COUNT);
    localparam logic signed [CNT_W:0]   TOL_S  = (CNT_W+1)'(TOL);

    state_t            state_q, state_d;
    logic              s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  half_q, half_d;
    logic              vld_q, vld_d;
    logic [15:0]       tog_q, tog_d;
    logic [MW-1:0]     match_q, match_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic              to_q, to_d;

    logic              edge_det;
    logic              in_tol;
    logic              to_hit;
    logic [MW-1:0]     match_inc;
    logic [CNT_W:0]    meas;
    logic signed [CNT_W:0] diff;

    assign edge_det  = s2_q ^ s3_q;
    assign meas      = {1'b0, cnt_q} + (CNT_W+1)'(1);
    // One bit wider than the counter so a long gap can never wrap into tolerance.
    assign diff      = $signed(meas) - NUM_S;
    assign in_tol    = (diff <= TOL_S) && (diff >= -TOL_S);
    assign to_hit    = (state_q != IDLE) && !edge_det && (cnt_q >= TO_LIM);
    assign match_inc = match_q + MW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default every comb output first so no path leaves it unassigned (no latch).
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else if (edge_det) begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   if (in_tol && (match_inc == LOCK_M)) state_d = LOCKED;
                LOCKED:  if (!in_tol) state_d = ARMED;
                default: state_d = IDLE;
            endcase
        end else if (to_hit) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        half_d   = half_q;
        vld_d    = 1'b0;
        tog_d    = tog_q;
        match_d  = match_q;
        err_d    = err_q;
        to_d     = to_q;
        locked_d = (state_d == LOCKED);
        if (clr) begin
            cnt_d   = '0;
            tog_d   = '0;
            match_d = '0;
            err_d   = 1'b0;
            to_d    = 1'b0;
        end else if (edge_det) begin
            cnt_d = '0;
            tog_d = tog_q + 16'd1;
            if (state_q != IDLE) begin
                half_d = meas[CNT_W-1:0];
                vld_d  = 1'b1;
            end
            case (state_q)
                IDLE:   match_d = '0;
                ARMED: begin
                    if (in_tol) begin
                        match_d = match_inc;
                    end else begin
                        match_d = '0;
                        err_d   = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!in_tol) begin
                        match_d = '0;
                        err_d   = 1'b1;
                    end
                end
                default: match_d = '0;
            endcase
        end else if (to_hit) begin
            to_d  = 1'b1;
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            cnt_q    <= '0;
            half_q   <= '0;
            vld_q    <= 1'b0;
            tog_q    <= '0;
            match_q  <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            s1_q     <= led_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            vld_q    <= vld_d;
            tog_q    <= tog_d;
            match_q  <= match_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            to_q     <= to_d;
        end
    end

    assign half_period = half_q;
    assign period_vld  = vld_q;
    assign toggles     = tog_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign timeout     = to_q;

endmodule

// File: tb/tb_led_blink_checker.sv
// Self-checking bench for led_blink_checker: directed vector table, corner-case
// sequences and random half-periods compared every cycle against a reference model.
module tb_led_blink_checker;

    localparam int N     = 5;
    localparam int T     = 1;
    localparam int W     = 24;
    localparam int LOCKN = 4;
    localparam int LIM   = 2 * (N + T);

    logic          clk = 1'b0;
    logic          rst;
    logic          led_in;
    logic          clr;
    logic [W-1:0]  half_period;
    logic          period_vld;
    logic [15:0]   toggles;
    logic          locked;
    logic          err;
    logic          timeout;

    int tests  = 0;
    int failed = 0;

    led_blink_checker #(.NUM_COUNT(N), .TOL(T), .CNT_W(W), .LOCK_N(LOCKN)) dut (
        .clk(clk), .rst(rst), .led_in(led_in), .clr(clr),
        .half_period(half_period), .period_vld(period_vld), .toggles(toggles),
        .locked(locked), .err(err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: edges are input changes delayed two samples; half-period is
    // the distance in cycles between consecutive detected edges.
    int          m_cyc, m_last, m_mode, m_match;
    logic [W-1:0] m_half;
    bit          m_vld, m_locked, m_err, m_to;
    logic [15:0] m_tog;
    bit          hist[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_last = 0; m_mode = 0; m_match = 0;
        m_half = '0; m_vld = 0; m_locked = 0; m_err = 0; m_to = 0; m_tog = '0;
        hist = {1'b0, 1'b0, 1'b0};
    endtask

    task automatic model_step(input bit l, input bit c);
        bit e, ok;
        int d;
        m_cyc++;
        e = (hist[1] != hist[0]);
        hist.push_back(l);
        void'(hist.pop_front());
        m_vld = 0;
        if (c) begin
            m_mode = 0; m_match = 0; m_tog = '0;
            m_err = 0; m_to = 0; m_locked = 0;
        end else if (e) begin
            m_tog++;
            if (m_mode == 0) begin
                m_mode = 1; m_match = 0;
            end else begin
                m_half = W'(m_cyc - m_last);
                m_vld  = 1;
                d  = (m_cyc - m_last) - N;
                ok = (d <= T) && (d >= -T);
                if (m_mode == 1) begin
                    if (ok) begin
                        m_match++;
                        if (m_match == LOCKN) begin m_mode = 2; m_locked = 1; end
                    end else begin
                        m_match = 0; m_err = 1;
                    end
                end else if (!ok) begin
                    m_mode = 1; m_locked = 0; m_err = 1; m_match = 0;
                end
            end
            m_last = m_cyc;
        end else if (m_mode != 0 && (m_cyc - m_last) > LIM) begin
            m_mode = 0; m_to = 1; m_err = 1; m_locked = 0;
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return 64'({half_period, period_vld, toggles, locked, err, timeout});
    endfunction

    function automatic logic [63:0] model_vec();
        return 64'({m_half, m_vld, m_tog, m_locked, m_err, m_to});
    endfunction

    // One clock: sample inputs at the edge, advance the model, compare all outputs.
    task automatic tick();
        bit l, c, r;
        l = led_in; c = clr; r = rst;
        @(posedge clk);
        if (r) model_reset();
        else   model_step(l, c);
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    // Flip led_in after hp cycles; returns three cycles after the flip, i.e. just
    // after the output update caused by that edge.
    task automatic flip(input int hp);
        repeat (hp - 3) tick();
        led_in = ~led_in;
        repeat (3) tick();
    endtask

    typedef struct {
        int hp;
        bit vld;
        int half;
        bit lck;
        bit er;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{3, 0, 0, 0, 0};
        tbl[1]  = '{5, 1, 5, 0, 0};
        tbl[2]  = '{5, 1, 5, 0, 0};
        tbl[3]  = '{5, 1, 5, 0, 0};
        tbl[4]  = '{5, 1, 5, 1, 0};
        tbl[5]  = '{4, 1, 4, 1, 0};
        tbl[6]  = '{6, 1, 6, 1, 0};
        tbl[7]  = '{8, 1, 8, 0, 1};
        tbl[8]  = '{5, 1, 5, 0, 1};
        tbl[9]  = '{5, 1, 5, 0, 1};
        tbl[10] = '{5, 1, 5, 0, 1};
        tbl[11] = '{5, 1, 5, 1, 1};
        tbl[12] = '{7, 1, 7, 0, 1};

        model_reset();
        rst = 1'b1; led_in = 1'b0; clr = 1'b0;
        repeat (4) begin
            led_in = ~led_in;
            tick();
        end
        check("reset_outputs", dut_vec(), 64'd0);
        rst = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 13; i++) begin
            flip(tbl[i].hp);
            check($sformatf("vec%0d_vld", i), 64'(period_vld), 64'(tbl[i].vld));
            check($sformatf("vec%0d_half", i), 64'(half_period), 64'(tbl[i].half));
            check($sformatf("vec%0d_locked", i), 64'(locked), 64'(tbl[i].lck));
            check($sformatf("vec%0d_err", i), 64'(err), 64'(tbl[i].er));
        end
        check("vec_toggles", 64'(toggles), 64'd13);

        // Relock from a clean status, then hold the LED until timeout.
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_err", 64'(err), 64'd0);
        for (int i = 0; i < 5; i++) flip(5);
        check("relock", 64'(locked), 64'd1);
        for (int k = 1; k <= LIM + 1; k++) begin
            tick();
            if (k == LIM) check("pre_timeout", 64'({timeout, err, locked}), 64'b001);
        end
        check("timeout", 64'({timeout, err, locked}), 64'b110);
        flip(5);
        check("idle_edge_vld", 64'(period_vld), 64'd0);

        // clr in the same cycle as an edge update.
        flip(5);
        led_in = ~led_in;
        tick(); tick();
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_edge", 64'({period_vld, toggles, err, timeout, locked}), 64'd0);
        flip(5);
        check("after_clr_vld", 64'(period_vld), 64'd0);
        flip(5);
        check("after_clr_half", 64'({period_vld, half_period}), {39'd0, 1'b1, 24'd5});

        // Asynchronous reset in the middle of a half-period.
        tick(); tick();
        #2 rst = 1'b1;
        #1 check("async_rst", dut_vec(), 64'd0);
        repeat (3) begin
            led_in = ~led_in;
            tick();
        end
        rst = 1'b0;
        flip(5);
        check("rst_first_edge", 64'(period_vld), 64'd0);
        flip(4);
        check("rst_second_edge", 64'({period_vld, half_period}), {39'd0, 1'b1, 24'd4});

        // Random half-periods, occasional long gaps and stray clears.
        for (int i = 0; i < 250; i++) begin
            int hp;
            hp = ($urandom_range(0, 14) == 0) ? LIM + 3 : int'($urandom_range(3, 9));
            repeat (hp) begin
                clr = ($urandom_range(0, 99) == 0);
                tick();
            end
            clr = 1'b0;
            led_in = ~led_in;
        end
        repeat (LIM + 4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/led_blink_checker.md
LED_BLINK_CHECKER -- requirements
Module: led_blink_checker

Interface
REQ-001 Parameter NUM_COUNT, default 5, expected LED half-period in clk cycles; NUM_COUNT SHALL be > TOL.
REQ-002 Parameter TOL, default 1, accepted deviation in cycles, |measured - NUM_COUNT| <= TOL.
REQ-003 Parameter CNT_W, default 24, cycle-counter width; 2*(NUM_COUNT+TOL) SHALL be < 2**CNT_W.
REQ-004 Parameter LOCK_N, default 4, consecutive in-tolerance half-periods required to lock.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 led_in  input  1  LED signal under test, asynchronous to clk.
REQ-008 clr  input  1  synchronous clear of status, counters and FSM.
REQ-009 half_period  output  CNT_W  last measured cycles between consecutive led_in edges.
REQ-010 period_vld  output  1  one-cycle pulse when half_period is updated.
REQ-011 toggles  output  16  count of detected led_in edges, wraps 16'hFFFF -> 0.
REQ-012 locked  output  1  high while LED blinks in tolerance.
REQ-013 err  output  1  sticky: out-of-tolerance half-period or timeout seen.
REQ-014 timeout  output  1  sticky: no edge within 2*(NUM_COUNT+TOL) cycles after arming.

Function
REQ-015 led_in SHALL pass through a 2-flop synchronizer (s1, s2) plus history flop s3; edge = s2 XOR s3.
REQ-016 A led_in change sampled at clk edge E SHALL produce registered output updates at edge E+2 (visible in the cycle after E+2).
REQ-017 Cycle counter cnt SHALL load 0 on edge, else increment, saturating at all-ones.
REQ-018 On edge in ARMED or LOCKED, half_period SHALL load cnt+1 (edge-to-edge distance) and period_vld SHALL pulse 1 cycle.
REQ-019 Tolerance check SHALL use CNT_W+1-bit signed arithmetic; no wrap in the subtraction.
REQ-020 Every edge SHALL increment toggles, in any state.
REQ-021 FSM states IDLE, ARMED, LOCKED; IDLE on reset and clr.
REQ-022 IDLE: first edge -> ARMED, match count 0, no period_vld.
REQ-023 ARMED: in-tolerance edge increments match count; reaching LOCK_N -> LOCKED, locked=1 same update; out-of-tolerance edge -> match count 0, err=1, stay ARMED.
REQ-024 LOCKED: in-tolerance edge stays; out-of-tolerance edge -> ARMED, locked=0, err=1, match count 0.
REQ-025 ARMED/LOCKED with cnt reaching 2*(NUM_COUNT+TOL) and no edge that cycle -> IDLE, timeout=1, err=1, locked=0.
REQ-026 Edge and timeout threshold in same cycle: edge wins, no timeout.
REQ-027 clr SHALL override an edge in the same cycle: state IDLE, cnt 0, toggles 0, err/timeout/locked 0, no period_vld; half_period holds.
REQ-028 err and timeout SHALL clear only by rst or clr.

Reset
REQ-029 rst SHALL asynchronously force s1/s2/s3=0, cnt=0, half_period=0, period_vld=0, toggles=0, locked=0, err=0, timeout=0, state IDLE.
REQ-030 rst asserted mid-measurement SHALL discard the partial count; first edge after release is treated as the IDLE edge.

Verification
REQ-031 Reset: rst=1 with led_in toggling -> all outputs 0; after release, no period_vld before second edge.
REQ-032 led_in toggles every 5 cycles (defaults) -> first edge no vld; each later edge half_period=5, period_vld 1 cycle; locked=1 on 5th edge; err=0; toggles counts every edge.
REQ-033 Locked, then one half-period of 8 -> half_period=8, err=1, locked=0; then 4 half-periods of 5 -> locked=1, err stays 1.
REQ-034 Boundaries TOL=1: half-periods 4 and 6 keep lock/count matches; 7 sets err.
REQ-035 Locked, led_in held constant -> timeout=1, err=1, locked=0 exactly when cnt reaches 12; next edge gives no period_vld (IDLE).
REQ-036 clr coincident with edge -> no period_vld, toggles=0, state IDLE; rst pulse mid-half-period -> outputs 0 immediately, asynchronously.
